// File: rtl/adc366x_tx_emu.sv
// Serial transmitter emulating a 5-lane ADC366x-style LVDS output: frame lane plus two bit
// lanes per channel, with stream/ramp/toggle sources, per-lane slip delay and inversion.
module adc366x_tx_emu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_en_i,
  input  logic [1:0]  cfg_pat_i,
  input  logic [4:0]  cfg_inv_i,
  input  logic [2:0]  cfg_slip_i,
  input  logic [31:0] s_dat_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [4:0]  ser_dat_o,
  output logic        sof_o,
  output logic [15:0] underrun_cnt_o
);

  localparam logic [1:0]  PatRamp   = 2'b01;
  localparam logic [1:0]  PatToggle = 2'b10;
  localparam logic [15:0] TogEven   = 16'h5555;
  localparam logic [15:0] TogOdd    = 16'hAAAA;

  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             frame_q, frame_d;
  logic [31:0]      hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [31:0]      last_q, last_d;
  logic [15:0]      sh_a_q, sh_a_d;
  logic [15:0]      sh_b_q, sh_b_d;
  logic [15:0]      ramp_q, ramp_d;
  logic             tog_q, tog_d;
  logic [7:0][4:0]  line_q, line_d;
  logic             sof_p_q, sof_p_d;
  logic             sof_q, sof_d;
  logic [4:0]       ser_q, ser_d;
  logic [15:0]      underrun_q, underrun_d;

  logic        load_now;
  logic        stream_sel;
  logic        accept;
  logic [4:0]  lane;
  logic [31:0] word;

  always_comb begin
    load_now   = (bit_cnt_q == 3'd7);
    stream_sel = (cfg_pat_i != PatRamp) && (cfg_pat_i != PatToggle);
    s_ready_o  = !rst_i && cfg_en_i && (!stream_sel || !hold_full_q || load_now);
    accept     = s_valid_i && s_ready_o;
    lane       = {sh_b_q[15], sh_b_q[14], sh_a_q[15], sh_a_q[14], frame_q};
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q + 3'd1;
    frame_d     = frame_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    sh_a_d      = {sh_a_q[13:0], 2'b00};
    sh_b_d      = {sh_b_q[13:0], 2'b00};
    ramp_d      = ramp_q;
    tog_d       = tog_q;
    underrun_d  = underrun_q;
    word        = last_q;

    if (load_now) begin
      unique case (cfg_pat_i)
        PatRamp: begin
          word   = {~ramp_q, ramp_q};
          ramp_d = ramp_q + 16'd1;
        end
        PatToggle: begin
          word  = tog_q ? {TogOdd, TogOdd} : {TogEven, TogEven};
          tog_d = !tog_q;
        end
        default: begin
          if (hold_full_q) begin
            word        = hold_q;
            hold_full_d = 1'b0;
          end else begin
            // Underrun: repeat the previous stream word.
            word       = last_q;
            underrun_d = (underrun_q == 16'hFFFF) ? underrun_q : underrun_q + 16'd1;
          end
          last_d = word;
        end
      endcase
      sh_a_d  = word[15:0];
      sh_b_d  = word[31:16];
      frame_d = !frame_q;
    end

    // Refill after the load so a same-cycle accept is not consumed.
    if (accept && stream_sel) begin
      hold_d      = s_dat_i;
      hold_full_d = 1'b1;
    end

    line_d  = {line_q[6:0], lane};
    ser_d   = line_q[cfg_slip_i] ^ cfg_inv_i;
    sof_p_d = (bit_cnt_q == 3'd0);
    sof_d   = sof_p_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !cfg_en_i) begin
      bit_cnt_q   <= '0;
      frame_q     <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      ramp_q      <= '0;
      tog_q       <= 1'b0;
      line_q      <= '0;
      sof_p_q     <= 1'b0;
      sof_q       <= 1'b0;
      ser_q       <= '0;
      if (rst_i) begin
        underrun_q <= '0;
      end
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      ramp_q      <= ramp_d;
      tog_q       <= tog_d;
      line_q      <= line_d;
      sof_p_q     <= sof_p_d;
      sof_q       <= sof_d;
      ser_q       <= ser_d;
      underrun_q  <= underrun_d;
    end
  end

  assign ser_dat_o      = ser_q;
  assign sof_o          = sof_q;
  assign underrun_cnt_o = underrun_q;

endmodule

// File: tb/tb_adc366x_tx_emu.sv
// Bench for adc366x_tx_emu: word-level model expanded into an expected serial bit stream,
// driven with randomized samples and pattern/config changes.
module tb_adc366x_tx_emu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_en_i = 1'b1;
  logic [1:0]  cfg_pat_i = 2'b00;
  logic [4:0]  cfg_inv_i = 5'b0;
  logic [2:0]  cfg_slip_i = 3'd0;
  logic [31:0] s_dat_i = 32'h0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [4:0]  ser_dat_o;
  logic        sof_o;
  logic [15:0] underrun_cnt_o;

  always #5 clk_i = ~clk_i;

  adc366x_tx_emu dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cfg_en_i       (cfg_en_i),
    .cfg_pat_i      (cfg_pat_i),
    .cfg_inv_i      (cfg_inv_i),
    .cfg_slip_i     (cfg_slip_i),
    .s_dat_i        (s_dat_i),
    .s_valid_i      (s_valid_i),
    .s_ready_o      (s_ready_o),
    .ser_dat_o      (ser_dat_o),
    .sof_o          (sof_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: serial stream element j = word j/8, bit j%8; n = active edges since (re)start.
  logic [4:0]  m_bits [$];
  int          n;
  bit          m_full;
  logic [31:0] m_hold, m_last;
  logic [15:0] m_ramp;
  bit          m_tog;
  int          m_words;
  logic [15:0] m_urun = 16'h0;
  logic [2:0]  e_slip;
  logic [4:0]  e_inv;

  function automatic void push_word(logic [31:0] w, bit frm);
    logic [15:0] a, b;
    a = w[15:0];
    b = w[31:16];
    for (int t = 0; t < 8; t++)
      m_bits.push_back({b[15-2*t], b[14-2*t], a[15-2*t], a[14-2*t], frm});
  endfunction

  function automatic void m_clear();
    m_bits.delete();
    push_word(32'h0, 1'b0);
    n = 0; m_full = 0; m_hold = 0; m_last = 0; m_ramp = 0; m_tog = 0; m_words = 0;
  endfunction

  function automatic bit is_stream(logic [1:0] p);
    return (p == 2'b00) || (p == 2'b11);
  endfunction

  function automatic logic m_ready();
    return !rst_i && cfg_en_i && (!is_stream(cfg_pat_i) || !m_full || (n % 8 == 7));
  endfunction

  function automatic logic [4:0] exp_ser();
    int idx;
    logic [4:0] b;
    if (n == 0) return 5'b0;
    idx = n - 2 - int'(e_slip);
    b = (idx < 0) ? 5'b0 : m_bits[idx];
    return b ^ e_inv;
  endfunction

  function automatic logic exp_sof();
    return (n >= 2) && ((n - 2) % 8 == 0);
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic clk_edge();
    bit load, acc, strm;
    logic [31:0] w, dat;
    logic [15:0] v;
    logic [1:0] pat;
    pat  = cfg_pat_i;
    strm = is_stream(pat);
    load = (n % 8 == 7);
    acc  = s_valid_i && m_ready();
    dat  = s_dat_i;
    e_slip = cfg_slip_i;
    e_inv  = cfg_inv_i;
    @(posedge clk_i);
    if (rst_i) begin
      m_clear();
      m_urun = 16'h0;
    end else if (!cfg_en_i) begin
      m_clear();
    end else begin
      if (load) begin
        if (pat == 2'b01) begin
          w = {~m_ramp, m_ramp};
          m_ramp = m_ramp + 16'd1;
        end else if (pat == 2'b10) begin
          v = m_tog ? 16'hAAAA : 16'h5555;
          w = {v, v};
          m_tog = !m_tog;
        end else begin
          if (m_full) begin
            w = m_hold;
            m_full = 0;
          end else begin
            w = m_last;
            if (m_urun != 16'hFFFF) m_urun = m_urun + 16'd1;
          end
          m_last = w;
        end
        m_words++;
        push_word(w, m_words[0]);
      end
      if (acc && strm) begin
        m_full = 1;
        m_hold = dat;
      end
      n++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    s_valid_i = 1'b0;
    cfg_en_i = 1'b1;
    clk_edge();
    clk_edge();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ser_dat_o !== 5'b0) $display("FAIL reset_ser got %b exp 00000", ser_dat_o);
    else n_pass++;
    n_checks++;
    if (sof_o !== 1'b0) $display("FAIL reset_sof got %b exp 0", sof_o);
    else n_pass++;
    n_checks++;
    if (s_ready_o !== 1'b0) $display("FAIL reset_ready got %b exp 0", s_ready_o);
    else n_pass++;
    n_checks++;
    if (underrun_cnt_o !== 16'h0) $display("FAIL reset_urun got %h exp 0000", underrun_cnt_o);
    else n_pass++;
    rst_i = 1'b0;
  endtask

  // Random stream traffic; optional random pattern switches and mid-run disable window.
  task automatic test_traffic(string name, int cycles, int vpct, bit rnd_pat, bit dis);
    for (int c = 0; c < cycles; c++) begin
      s_valid_i = ($urandom_range(0, 99) < vpct);
      s_dat_i   = (c == 0) ? 32'h1234ABCD : $urandom;
      if (rnd_pat && (c % 5 == 0)) cfg_pat_i = 2'($urandom_range(0, 3));
      if (dis) cfg_en_i = !(c >= 21 && c < 24);
      #1;
      n_checks++;
      if (s_ready_o !== m_ready())
        $display("FAIL %s ready n=%0d got %b exp %b", name, n, s_ready_o, m_ready());
      else n_pass++;
      clk_edge();
      n_checks++;
      if ({sof_o, ser_dat_o} !== {exp_sof(), exp_ser()})
        $display("FAIL %s sof/ser n=%0d got %b_%b exp %b_%b", name, n, sof_o, ser_dat_o,
                 exp_sof(), exp_ser());
      else n_pass++;
    end
    n_checks++;
    if (underrun_cnt_o !== m_urun)
      $display("FAIL %s underrun got %0d exp %0d", name, underrun_cnt_o, m_urun);
    else n_pass++;
  endtask

  task automatic test_stream();
    do_reset(); rst_i = 1'b0; cfg_pat_i = 2'b00; cfg_slip_i = 3'd0; cfg_inv_i = 5'b0;
    test_traffic("stream", 160, 60, 1'b0, 1'b0);
  endtask

  task automatic test_underrun();
    do_reset(); rst_i = 1'b0; cfg_pat_i = 2'b00;
    test_traffic("underrun_fill", 1, 100, 1'b0, 1'b0);
    test_traffic("underrun", 33, 0, 1'b0, 1'b0);
    n_checks++;
    if (underrun_cnt_o !== 16'd3) $display("FAIL underrun_three got %0d exp 3", underrun_cnt_o);
    else n_pass++;
  endtask

  task automatic test_ramp();
    do_reset(); rst_i = 1'b0; cfg_pat_i = 2'b01;
    test_traffic("ramp", 48, 50, 1'b0, 1'b0);
  endtask

  task automatic test_toggle();
    do_reset(); rst_i = 1'b0; cfg_pat_i = 2'b10;
    test_traffic("toggle", 40, 50, 1'b0, 1'b0);
  endtask

  task automatic test_slip_inv();
    do_reset(); rst_i = 1'b0; cfg_pat_i = 2'b00; cfg_slip_i = 3'd3; cfg_inv_i = 5'b00001;
    test_traffic("slip3_inv", 64, 80, 1'b0, 1'b0);
    cfg_slip_i = 3'd7; cfg_inv_i = 5'b10110;
    test_traffic("slip7_inv", 40, 80, 1'b0, 1'b0);
    cfg_slip_i = 3'd0; cfg_inv_i = 5'b0;
  endtask

  task automatic test_pattern_switch();
    do_reset(); rst_i = 1'b0;
    test_traffic("pat_switch", 120, 40, 1'b1, 1'b0);
    cfg_pat_i = 2'b00;
  endtask

  task automatic test_back_to_back();
    int pulses;
    do_reset(); rst_i = 1'b0; cfg_pat_i = 2'b00;
    test_traffic("b2b_fill", 8, 100, 1'b0, 1'b0);
    pulses = 0;
    for (int c = 0; c < 32; c++) begin
      s_valid_i = 1'b1;
      s_dat_i = $urandom;
      #1;
      if (s_ready_o === 1'b1) pulses++;
      clk_edge();
    end
    n_checks++;
    if (pulses !== 4) $display("FAIL b2b_pulses got %0d exp 4", pulses);
    else n_pass++;
    test_traffic("b2b", 24, 100, 1'b0, 1'b0);
    n_checks++;
    if (underrun_cnt_o !== 16'h0) $display("FAIL b2b_urun got %0d exp 0", underrun_cnt_o);
    else n_pass++;
  endtask

  task automatic test_disable();
    do_reset(); rst_i = 1'b0; cfg_pat_i = 2'b00;
    test_traffic("disable", 80, 30, 1'b0, 1'b1);
    cfg_en_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset(); rst_i = 1'b0; cfg_pat_i = 2'b00;
    test_traffic("rstmid_pre", 20, 20, 1'b0, 1'b0);
    for (int c = 0; c < 8 && (n % 8 != 4); c++) test_traffic("rstmid_align", 1, 20, 1'b0, 1'b0);
    rst_i = 1'b1;
    s_valid_i = 1'b1;
    clk_edge();
    n_checks++;
    if ({sof_o, ser_dat_o, s_ready_o, underrun_cnt_o} !== 23'h0)
      $display("FAIL rstmid_zero got sof=%b ser=%b rdy=%b urun=%0d exp all 0",
               sof_o, ser_dat_o, s_ready_o, underrun_cnt_o);
    else n_pass++;
    rst_i = 1'b0;
    test_traffic("rstmid_post", 32, 70, 1'b0, 1'b0);
  endtask

  initial begin
    m_clear();
    e_slip = 3'd0;
    e_inv = 5'b0;
    test_reset();
    test_stream();
    test_underrun();
    test_ramp();
    test_toggle();
    test_slip_inv();
    test_pattern_switch();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
